// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding and line/parity levels.
package uart_tx_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = IDLE,
    S_START  = START,
    S_DATA   = DATA,
    S_PARITY = PARITY,
    S_STOP   = STOP
  } state_t;

  localparam logic PAR_EVEN    = 1'b0;
  localparam logic PAR_ODD     = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_frame_ctrl_parity_calc.sv
// Combinational parity generator: even parity when typ is PAR_EVEN, odd when PAR_ODD.
module parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  typ,
  output logic                  par_bit
);

  assign par_bit = (^data) ^ (typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame controller: latches a word, sequences START/DATA/PARITY/STOP,
// hands the data phase to the serializer and aborts a stalled serializer.
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int WDOG_CYCLES = DATA_WIDTH + 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic [DATA_WIDTH-1:0] ser_p_data,
  output logic                  ser_en,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  state_t             state, state_nxt;
  logic [WDOG_W-1:0]  wdog;
  logic               par_en_q;
  logic               par_bit;
  logic               par_bit_calc;
  logic               accept;
  logic               wdog_expired;

  parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity_calc (
    .data    (P_DATA),
    .typ     (PAR_TYP),
    .par_bit (par_bit_calc)
  );

  // A new word is taken only between frames, so the latched word stays put mid-frame.
  assign accept       = DATA_VALID && (state == S_IDLE || state == S_STOP);
  assign wdog_expired = (state == S_DATA) && !ser_done && (wdog == WDOG_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (accept) state_nxt = S_START;
      S_START:  state_nxt = S_DATA;
      S_DATA: begin
        if (ser_done)          state_nxt = par_en_q ? S_PARITY : S_STOP;
        else if (wdog_expired) state_nxt = S_STOP;
      end
      S_PARITY: state_nxt = S_STOP;
      S_STOP:   state_nxt = accept ? S_START : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Line mux follows the registered state, so reset forces the idle level without a clock.
  always_comb begin
    TX_OUT = IDLE_LEVEL;
    unique case (state)
      S_IDLE:   TX_OUT = IDLE_LEVEL;
      S_START:  TX_OUT = START_LEVEL;
      S_DATA:   TX_OUT = ser_data;
      S_PARITY: TX_OUT = par_bit;
      S_STOP:   TX_OUT = IDLE_LEVEL;
      default:  TX_OUT = IDLE_LEVEL;
    endcase
  end

  assign busy   = (state != S_IDLE);
  assign ser_en = (state == S_START) || (state == S_DATA);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ser_p_data <= '0;
      par_en_q   <= 1'b0;
      par_bit    <= 1'b0;
    end else if (accept) begin
      ser_p_data <= P_DATA;
      par_en_q   <= PAR_EN;
      par_bit    <= par_bit_calc;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wdog      <= '0;
      frame_err <= 1'b0;
    end else begin
      if (state_nxt == S_START) wdog <= '0;
      else if (state == S_DATA) wdog <= wdog + 1'b1;
      frame_err <= wdog_expired;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed bench for uart_tx_frame_ctrl with a small LSB-first serializer model.
module tb_uart_tx_frame_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       ser_done;
  logic       ser_data;
  logic [7:0] ser_p_data;
  logic       ser_en;
  logic       TX_OUT;
  logic       busy;
  logic       frame_err;

  int n_cmp = 0;
  int n_err = 0;

  // serializer model: starts on the edge that leaves START, one bit per cycle
  logic       hang = 1'b0;
  logic       ser_active;
  logic [2:0] ser_idx;

  always #5 CLK = ~CLK;

  uart_tx_frame_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_done   (ser_done),
    .ser_data   (ser_data),
    .ser_p_data (ser_p_data),
    .ser_en     (ser_en),
    .TX_OUT     (TX_OUT),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      ser_active <= 1'b0;
      ser_idx    <= 3'd0;
    end else if (!ser_en) begin
      ser_active <= 1'b0;
    end else if (!ser_active) begin
      ser_active <= 1'b1;
      ser_idx    <= 3'd0;
    end else if (ser_idx != 3'd7) begin
      ser_idx <= ser_idx + 3'd1;
    end
  end

  assign ser_data = ser_active ? ser_p_data[ser_idx] : 1'b0;
  assign ser_done = ser_active && (ser_idx == 3'd7) && !hang;

  // Expected line level at frame cycle i (0 = START).
  function automatic logic exp_tx(input logic [7:0] w, input logic pen,
                                  input logic par, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return w[i-1];
    if (i == 9 && pen) return par;
    return 1'b1;
  endfunction

  task automatic test_reset();
    #2;
    n_cmp++; if (TX_OUT !== 1'b1)     begin n_err++; $display("FAIL reset_tx got=%b exp=1", TX_OUT); end
    n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (ser_en !== 1'b0)     begin n_err++; $display("FAIL reset_ser_en got=%b exp=0", ser_en); end
    n_cmp++; if (frame_err !== 1'b0)  begin n_err++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    n_cmp++; if (ser_p_data !== 8'h00) begin n_err++; $display("FAIL reset_ser_p_data got=%h exp=00", ser_p_data); end
    @(negedge CLK); RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0 || ser_en !== 1'b0)
        begin n_err++; $display("FAIL reset_idle[%0d] got tx=%b busy=%b en=%b exp tx=1 busy=0 en=0", i, TX_OUT, busy, ser_en); end
    end
  endtask

  task automatic test_frame(input logic [7:0] w, input logic pen, input logic ptyp,
                            input logic par, input string name);
    int len;
    len = 10 + int'(pen);
    @(negedge CLK);
    P_DATA = w; PAR_EN = pen; PAR_TYP = ptyp; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (i < len) begin
        n_cmp++;
        if (TX_OUT !== exp_tx(w, pen, par, i))
          begin n_err++; $display("FAIL %s_tx[%0d] got=%b exp=%b", name, i, TX_OUT, exp_tx(w, pen, par, i)); end
        n_cmp++;
        if (busy !== 1'b1 || ser_en !== (i <= 8) || frame_err !== 1'b0 || ser_p_data !== w)
          begin n_err++; $display("FAIL %s_ctl[%0d] got busy=%b en=%b ferr=%b word=%h exp busy=1 en=%b ferr=0 word=%h",
                                  name, i, busy, ser_en, frame_err, ser_p_data, (i <= 8), w); end
      end else begin
        n_cmp++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0)
          begin n_err++; $display("FAIL %s_end got tx=%b busy=%b exp tx=1 busy=0", name, TX_OUT, busy); end
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge CLK);
    P_DATA = 8'h00; PAR_EN = 1'b1; PAR_TYP = PAR_TYP; DATA_VALID = 1'b1;
    @(negedge CLK); DATA_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (TX_OUT !== 1'b0 || busy !== 1'b1 || ser_en !== 1'b1)
      begin n_err++; $display("FAIL midrst_pre got tx=%b busy=%b en=%b exp tx=0 busy=1 en=1", TX_OUT, busy, ser_en); end
    #2 RST = 1'b1;
    #1;
    n_cmp++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0 || ser_en !== 1'b0 || ser_p_data !== 8'h00)
      begin n_err++; $display("FAIL midrst_async got tx=%b busy=%b en=%b word=%h exp tx=1 busy=0 en=0 word=00",
                              TX_OUT, busy, ser_en, ser_p_data); end
    @(negedge CLK); RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0 || ser_en !== 1'b0 || frame_err !== 1'b0)
        begin n_err++; $display("FAIL midrst_after[%0d] got tx=%b busy=%b en=%b ferr=%b exp tx=1 busy=0 en=0 ferr=0",
                                i, TX_OUT, busy, ser_en, frame_err); end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge CLK);
    P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    @(negedge CLK);
    P_DATA = 8'hFF;
    for (int i = 0; i <= 20; i++) begin
      if (i < 10) begin
        n_cmp++;
        if (TX_OUT !== exp_tx(8'h3C, 1'b0, 1'b0, i) || busy !== 1'b1 || ser_p_data !== 8'h3C)
          begin n_err++; $display("FAIL b2b_first[%0d] got tx=%b busy=%b word=%h exp tx=%b busy=1 word=3c",
                                  i, TX_OUT, busy, ser_p_data, exp_tx(8'h3C, 1'b0, 1'b0, i)); end
      end else if (i < 20) begin
        n_cmp++;
        if (TX_OUT !== exp_tx(8'hFF, 1'b0, 1'b0, i - 10) || busy !== 1'b1 || ser_p_data !== 8'hFF)
          begin n_err++; $display("FAIL b2b_second[%0d] got tx=%b busy=%b word=%h exp tx=%b busy=1 word=ff",
                                  i - 10, TX_OUT, busy, ser_p_data, exp_tx(8'hFF, 1'b0, 1'b0, i - 10)); end
        if (i == 10) DATA_VALID = 1'b0;
      end else begin
        n_cmp++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0)
          begin n_err++; $display("FAIL b2b_end got tx=%b busy=%b exp tx=1 busy=0", TX_OUT, busy); end
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_watchdog();
    int pulses;
    pulses = 0;
    hang = 1'b1;
    @(negedge CLK);
    P_DATA = 8'h81; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    @(negedge CLK); DATA_VALID = 1'b0;
    for (int i = 0; i <= 13; i++) begin
      if (frame_err === 1'b1) pulses++;
      n_cmp++;
      if (frame_err !== (i == 11) || busy !== (i <= 11) || ser_en !== (i <= 10))
        begin n_err++; $display("FAIL wdog_ctl[%0d] got ferr=%b busy=%b en=%b exp ferr=%b busy=%b en=%b",
                                i, frame_err, busy, ser_en, (i == 11), (i <= 11), (i <= 10)); end
      if (i == 0 || i >= 11) begin
        n_cmp++;
        if (TX_OUT !== (i != 0))
          begin n_err++; $display("FAIL wdog_tx[%0d] got=%b exp=%b", i, TX_OUT, (i != 0)); end
      end
      @(negedge CLK);
    end
    n_cmp++;
    if (pulses != 1) begin n_err++; $display("FAIL wdog_pulses got=%0d exp=1", pulses); end
    hang = 1'b0;
  endtask

  task automatic test_dv_ignored();
    @(negedge CLK);
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    @(negedge CLK); DATA_VALID = 1'b0;
    for (int i = 0; i <= 13; i++) begin
      if (i < 11) begin
        n_cmp++;
        if (TX_OUT !== exp_tx(8'hA5, 1'b1, 1'b0, i) || ser_p_data !== 8'hA5 || busy !== 1'b1)
          begin n_err++; $display("FAIL dvign[%0d] got tx=%b word=%h busy=%b exp tx=%b word=a5 busy=1",
                                  i, TX_OUT, ser_p_data, busy, exp_tx(8'hA5, 1'b1, 1'b0, i)); end
      end else begin
        n_cmp++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0 || ser_p_data !== 8'hA5)
          begin n_err++; $display("FAIL dvign_idle[%0d] got tx=%b busy=%b word=%h exp tx=1 busy=0 word=a5",
                                  i, TX_OUT, busy, ser_p_data); end
      end
      if (i >= 1 && i <= 7) begin
        DATA_VALID = i[0];
        P_DATA     = 8'h5A ^ 8'(i);
      end else begin
        DATA_VALID = 1'b0;
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5, 1'b1, 1'b0, 1'b0, "a5_even");
    test_frame(8'hA5, 1'b1, 1'b1, 1'b1, "a5_odd");
    test_frame(8'hA5, 1'b0, 1'b0, 1'b0, "a5_nopar");
    test_frame(8'h01, 1'b1, 1'b0, 1'b1, "01_even");
    test_reset_mid_frame();
    test_back_to_back();
    test_watchdog();
    test_dv_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
